cond_exec_stage: RTL and testbench
==================================

Name: cond_exec_stage

Overview:
- Execute-stage conditional-execution unit for the pipelined ARMv4 core.
- Registers decode-stage control into the E stage and holds the architectural NZCV flags register.
- Evaluates the instruction's condition field against the current flags, and gates PCS/RegW/MemW with the result.
- Updates flags from the ALU, registers the gated controls into M, and keeps executed/skipped instruction counters.

Parameters:
CNT_W, 32, width of ExecCount and SkipCount performance counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
StallE  input  1  hold E-stage register contents
FlushE  input  1  insert bubble into E stage
ValidD  input  1  decode stage holds a real instruction
CondD  input  4  condition field, Instr[31:28]
FlagWD  input  2  flag write enables: [1]=N,Z; [0]=C,V
PCSD  input  1  instruction writes PC
RegWD  input  1  instruction writes register file
MemWD  input  1  instruction writes memory
NoWriteD  input  1  compare-type op, suppress register write
ALUFlagsE  input  4  {N,Z,C,V} from ALU for instruction in E
CondExE  output  1  E instruction is valid and its condition passes
PCSrcE  output  1  gated PC write
RegWriteE  output  1  gated register write
MemWriteE  output  1  gated memory write
FlagsQ  output  4  architectural {N,Z,C,V}
ValidM  output  1  M stage holds an executed or skipped instruction
PCSrcM  output  1  registered PCSrcE
RegWriteM  output  1  registered RegWriteE
MemWriteM  output  1  registered MemWriteE
ExecCount  output  CNT_W  instructions whose condition passed
SkipCount  output  CNT_W  instructions whose condition failed

Behaviour:
- Single clock domain. Reset is synchronous and active-high, and overrides all other inputs.
- On reset:
  - E register is cleared (ValidE=0, CondE=0, all controls 0).
  - FlagsQ=0000.
  - M register is cleared: ValidM, PCSrcM, RegWriteM and MemWriteM are all 0.
  - ExecCount=0 and SkipCount=0.
  - All combinational outputs evaluate to 0.
- E register update, in priority order:
  - FlushE=1: load a bubble (ValidE=0, controls 0). Flush wins over StallE.
  - StallE=1: hold.
  - Otherwise: load ValidD, CondD, FlagWD, PCSD, RegWD, MemWD, NoWriteD.
- Condition evaluation is combinational on CondE and FlagsQ:
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~(C&~Z)
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE ~(~Z&(N==V))
  - 1110 AL 1
  - 1111 evaluates to 0 (never executes; no X propagation).
- Gating equations:
  - CondExE = ValidE & pass.
  - PCSrcE = PCSE & CondExE.
  - RegWriteE = RegWE & CondExE & ~NoWriteE.
  - MemWriteE = MemWE & CondExE.
- Flag write occurs at the clock edge when CondExE & ~StallE:
  - FlagWE[1] → FlagsQ[3:2] <= ALUFlagsE[3:2].
  - FlagWE[0] → FlagsQ[1:0] <= ALUFlagsE[1:0].
  - Unselected flags are unchanged.
  - A failed condition never writes flags.
- Flag latency: a flag-setting instruction updates FlagsQ at the end of its E cycle. The next instruction in E sees the new flags with no bubble; no forwarding path is needed.
- FlushE affects only the incoming instruction. The instruction currently in E still completes: flags, counters and M register are all updated.
- M register update (ignores FlushE):
  - ValidM <= ValidE & ~StallE.
  - PCSrcM/RegWriteM/MemWriteM <= gated E value & ~StallE.
  - While E is stalled, M receives bubbles, so each instruction reaches M exactly once.
- Counters:
  - ExecCount increments on ValidE & ~StallE & CondExE.
  - SkipCount increments on ValidE & ~StallE & ~CondExE.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-operation: the in-flight E instruction is discarded, with no flag or counter update in that cycle.

Test Plan:
1. Assert reset for 2 cycles with random D inputs and ALUFlagsE=1111 → FlagsQ=0000, all outputs 0, counters 0; outputs remain 0 one cycle after release with ValidD=0.
2. Back-to-back flag dependency:
   - Stimulus: CMP (CondD=1110, FlagWD=11, NoWriteD=1, RegWD=1, ALUFlagsE=0100), then CondD=0000 with RegWD=1.
   - Response: CMP has RegWriteE=0; FlagsQ=0100 after the CMP; the second instruction has CondExE=1 and RegWriteE=1; ExecCount=2.
3. Partial flag write: from FlagsQ=1111, an AL instruction with FlagWD=10 and ALUFlagsE=0000 → FlagsQ=0011; then FlagWD=01 with ALUFlagsE=0000 → FlagsQ=0000.
4. Failed condition:
   - Stimulus: FlagsQ=0000; CondD=0000 with PCSD=1, MemWD=1, FlagWD=11, ALUFlagsE=1111.
   - Response: CondExE=0, PCSrcE=0, MemWriteE=0; FlagsQ stays 0000; SkipCount +1; next cycle ValidM=1 with MemWriteM=0.
5. Stall/flush:
   - StallE=1 for 3 cycles with a flag-setting AL instruction in E → E holds; ValidM=0 during the stall; FlagsQ and ExecCount update only on the release cycle.
   - FlushE=1 and StallE=1 together → next cycle ValidE=0, CondExE=0.
6. Wrap, boundary and mid-stream reset, with CNT_W=4:
   - 16 executed AL instructions → ExecCount returns to 0.
   - CondD=1111 → CondExE=0, SkipCount +1.
   - Reset mid-stream → no flag update that cycle.

Source files
------------

// File: rtl/cond_exec_stage.sv
// cond_exec_stage
// ---------------
// Execute-stage conditional-execution unit for a pipelined ARMv4 core.
// It registers decode-stage control into E and holds the architectural
// NZCV flags. It tests the condition field of the E instruction against
// those flags and gates the PC, register and memory writes with the result.
// The gated controls are registered into M, and counters track how many
// instructions executed and how many were skipped.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   StallE, FlushE       : E-stage hold / bubble insertion (flush wins)
//   ValidD, CondD,
//   FlagWD, PCSD, RegWD,
//   MemWD, NoWriteD      : decode-stage instruction control
//   ALUFlagsE            : {N,Z,C,V} produced by the ALU for the E instruction
//   CondExE              : E instruction is valid and its condition passes
//   PCSrcE, RegWriteE,
//   MemWriteE            : gated E-stage writes (combinational)
//   FlagsQ               : architectural {N,Z,C,V}
//   ValidM, PCSrcM,
//   RegWriteM, MemWriteM : M-stage register
//   ExecCount, SkipCount : executed / skipped instruction counters (wrapping)
//
// Valid/stall semantics: an instruction with ValidE=1 leaves E on a clock
// edge where StallE=0. On that edge, and only then, it updates the flags
// (if it executes) and bumps exactly one counter, and it appears in M with
// ValidM=1. A stalled edge sends a bubble into M, so each instruction
// reaches M exactly once.

module cond_exec_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallE,
   input  logic             FlushE,
   input  logic             ValidD,
   input  logic [3:0]       CondD,
   input  logic [1:0]       FlagWD,
   input  logic             PCSD,
   input  logic             RegWD,
   input  logic             MemWD,
   input  logic             NoWriteD,
   input  logic [3:0]       ALUFlagsE,
   output logic             CondExE,
   output logic             PCSrcE,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic [3:0]       FlagsQ,
   output logic             ValidM,
   output logic             PCSrcM,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SkipCount
);

   // E-stage register
   logic       r_valid_e;
   logic [3:0] r_cond_e;
   logic [1:0] r_flagw_e;
   logic       r_pcs_e;
   logic       r_regw_e;
   logic       r_memw_e;
   logic       r_nowrite_e;

   // Architectural flags, M-stage register, counters
   logic [3:0]       r_flags;
   logic             r_valid_m;
   logic             r_pcsrc_m;
   logic             r_regw_m;
   logic             r_memw_m;
   logic [CNT_W-1:0] r_exec_cnt;
   logic [CNT_W-1:0] r_skip_cnt;

   logic w_n, w_z, w_c, w_v;
   logic w_pass;
   logic w_condex;
   logic w_pcsrc_e;
   logic w_regw_e;
   logic w_memw_e;
   logic w_leave_e;

   // E register: flush loads a bubble even while stalled
   always_ff @(posedge clk) begin
      if (reset || FlushE) begin
         r_valid_e   <= 1'b0;
         r_cond_e    <= 4'b0000;
         r_flagw_e   <= 2'b00;
         r_pcs_e     <= 1'b0;
         r_regw_e    <= 1'b0;
         r_memw_e    <= 1'b0;
         r_nowrite_e <= 1'b0;
      end else if (!StallE) begin
         r_valid_e   <= ValidD;
         r_cond_e    <= CondD;
         r_flagw_e   <= FlagWD;
         r_pcs_e     <= PCSD;
         r_regw_e    <= RegWD;
         r_memw_e    <= MemWD;
         r_nowrite_e <= NoWriteD;
      end
   end

   assign w_n = r_flags[3];
   assign w_z = r_flags[2];
   assign w_c = r_flags[1];
   assign w_v = r_flags[0];

   // Condition check; 4'b1111 is the never-execute encoding
   always_comb begin
      w_pass = 1'b0;
      case (r_cond_e)
         4'b0000: w_pass = w_z;
         4'b0001: w_pass = ~w_z;
         4'b0010: w_pass = w_c;
         4'b0011: w_pass = ~w_c;
         4'b0100: w_pass = w_n;
         4'b0101: w_pass = ~w_n;
         4'b0110: w_pass = w_v;
         4'b0111: w_pass = ~w_v;
         4'b1000: w_pass = w_c & ~w_z;
         4'b1001: w_pass = ~(w_c & ~w_z);
         4'b1010: w_pass = (w_n == w_v);
         4'b1011: w_pass = (w_n != w_v);
         4'b1100: w_pass = ~w_z & (w_n == w_v);
         4'b1101: w_pass = ~(~w_z & (w_n == w_v));
         4'b1110: w_pass = 1'b1;
         default: w_pass = 1'b0;
      endcase
   end

   assign w_condex  = r_valid_e & w_pass;
   assign w_pcsrc_e = r_pcs_e & w_condex;
   assign w_regw_e  = r_regw_e & w_condex & ~r_nowrite_e;
   assign w_memw_e  = r_memw_e & w_condex;
   assign w_leave_e = r_valid_e & ~StallE;

   // Flags are written when the instruction leaves E, so the next
   // instruction sees them in its own E cycle without forwarding.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else if (w_condex && !StallE) begin
         if (r_flagw_e[1]) r_flags[3:2] <= ALUFlagsE[3:2];
         if (r_flagw_e[0]) r_flags[1:0] <= ALUFlagsE[1:0];
      end
   end

   // M register ignores FlushE: the instruction already in E completes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_m <= 1'b0;
         r_pcsrc_m <= 1'b0;
         r_regw_m  <= 1'b0;
         r_memw_m  <= 1'b0;
      end else begin
         r_valid_m <= w_leave_e;
         r_pcsrc_m <= w_pcsrc_e & ~StallE;
         r_regw_m  <= w_regw_e & ~StallE;
         r_memw_m  <= w_memw_e & ~StallE;
      end
   end

   // Counters wrap naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (reset) begin
         r_exec_cnt <= '0;
         r_skip_cnt <= '0;
      end else if (w_leave_e) begin
         if (w_condex) r_exec_cnt <= r_exec_cnt + CNT_W'(1);
         else          r_skip_cnt <= r_skip_cnt + CNT_W'(1);
      end
   end

   assign CondExE   = w_condex;
   assign PCSrcE    = w_pcsrc_e;
   assign RegWriteE = w_regw_e;
   assign MemWriteE = w_memw_e;
   assign FlagsQ    = r_flags;
   assign ValidM    = r_valid_m;
   assign PCSrcM    = r_pcsrc_m;
   assign RegWriteM = r_regw_m;
   assign MemWriteM = r_memw_m;
   assign ExecCount = r_exec_cnt;
   assign SkipCount = r_skip_cnt;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Testbench for cond_exec_stage (CNT_W=4). Directed instructions carry
// hand-computed expectations: E-stage gating is checked while the
// instruction sits in E, and the M-stage record {PCSrcM,RegWriteM,MemWriteM,
// FlagsQ,ExecCount,SkipCount} is queued at issue and checked by a monitor
// whenever ValidM is high.

module tb_cond_exec_stage;

   localparam int CNT_W = 4;

   // ---------------- clock / reset / DUT ----------------
   logic             clk;
   logic             reset;
   logic             StallE;
   logic             FlushE;
   logic             ValidD;
   logic [3:0]       CondD;
   logic [1:0]       FlagWD;
   logic             PCSD;
   logic             RegWD;
   logic             MemWD;
   logic             NoWriteD;
   logic [3:0]       ALUFlagsE;
   logic             CondExE;
   logic             PCSrcE;
   logic             RegWriteE;
   logic             MemWriteE;
   logic [3:0]       FlagsQ;
   logic             ValidM;
   logic             PCSrcM;
   logic             RegWriteM;
   logic             MemWriteM;
   logic [CNT_W-1:0] ExecCount;
   logic [CNT_W-1:0] SkipCount;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cond_exec_stage #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .StallE    (StallE),
      .FlushE    (FlushE),
      .ValidD    (ValidD),
      .CondD     (CondD),
      .FlagWD    (FlagWD),
      .PCSD      (PCSD),
      .RegWD     (RegWD),
      .MemWD     (MemWD),
      .NoWriteD  (NoWriteD),
      .ALUFlagsE (ALUFlagsE),
      .CondExE   (CondExE),
      .PCSrcE    (PCSrcE),
      .RegWriteE (RegWriteE),
      .MemWriteE (MemWriteE),
      .FlagsQ    (FlagsQ),
      .ValidM    (ValidM),
      .PCSrcM    (PCSrcM),
      .RegWriteM (RegWriteM),
      .MemWriteM (MemWriteM),
      .ExecCount (ExecCount),
      .SkipCount (SkipCount)
   );

   // ---------------- scoreboard state ----------------
   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [14:0] exp_q[$];
   logic [3:0]  pend_ctl;   // expected {CondExE,PCSrcE,RegWriteE,MemWriteE} of E instr
   logic [3:0]  pend_alu;   // ALUFlagsE to present while that instr is in E

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({CondExE, PCSrcE, RegWriteE, MemWriteE, FlagsQ,
                  ValidM, PCSrcM, RegWriteM, MemWriteM, ExecCount, SkipCount});
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && ValidM) begin
         if (exp_q.size() == 0) begin
            chk("m_unexpected", 32'(ValidM), 32'd0);
         end else begin
            logic [14:0] exp_rec;
            exp_rec = exp_q.pop_front();
            chk("m_record", 32'({PCSrcM, RegWriteM, MemWriteM, FlagsQ, ExecCount, SkipCount}),
                32'(exp_rec));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_d(input logic v, input logic [3:0] c, input logic [1:0] fw,
                        input logic p, input logic r, input logic m, input logic n);
      ValidD   = v;
      CondD    = c;
      FlagWD   = fw;
      PCSD     = p;
      RegWD    = r;
      MemWD    = m;
      NoWriteD = n;
   endtask

   // One cycle: check the instr currently in E, present its ALU flags, and
   // drive the next instruction into D. e_ctl = {CondEx,PCSrc,RegWrite,MemWrite}.
   task automatic issue(input logic v, input logic [3:0] c, input logic [1:0] fw,
                        input logic p, input logic r, input logic m, input logic n,
                        input logic [3:0] alu, input logic flush, input logic push,
                        input logic [3:0] e_ctl, input logic [3:0] e_flags,
                        input logic [3:0] e_exec, input logic [3:0] e_skip);
      @(negedge clk);
      chk("e_ctl", 32'({CondExE, PCSrcE, RegWriteE, MemWriteE}), 32'(pend_ctl));
      StallE    = 1'b0;
      FlushE    = flush;
      ALUFlagsE = pend_alu;
      set_d(v, c, fw, p, r, m, n);
      if (flush) begin
         pend_ctl = 4'b0000;
         pend_alu = 4'b0000;
      end else begin
         pend_ctl = v ? e_ctl : 4'b0000;
         pend_alu = alu;
         if (push && v) exp_q.push_back({e_ctl[2:0], e_flags, e_exec, e_skip});
      end
   endtask

   task automatic bubble();
      issue(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0,
            4'b0000, 4'h0, 4'h0, 4'h0);
   endtask

   // Hold the E instruction for n edges; flags, counters and M must not move.
   task automatic stall(input int n, input logic [3:0] e_flags, input logic [3:0] e_exec);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("stall_e_ctl", 32'({CondExE, PCSrcE, RegWriteE, MemWriteE}), 32'(pend_ctl));
         chk("stall_flags", 32'(FlagsQ), 32'(e_flags));
         chk("stall_exec", 32'(ExecCount), 32'(e_exec));
         chk("stall_validm", 32'(ValidM), 32'd0);
         StallE    = 1'b1;
         ALUFlagsE = pend_alu;
         set_d(1'b1, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t;
      reset     = 1'b1;
      StallE    = 1'b0;
      FlushE    = 1'b0;
      ALUFlagsE = 4'hF;
      pend_ctl  = 4'b0000;
      pend_alu  = 4'b0000;
      set_d(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset with random decode inputs
      for (int i = 0; i < 2; i++) begin
         set_d(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         @(posedge clk);
      end
      @(negedge clk);
      chk("reset_state", all_outs(), 32'd0);
      reset     = 1'b0;
      ALUFlagsE = 4'h0;
      set_d(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_reset", all_outs(), 32'd0);

      //    v     cond   fw     pcs   rw    mw    nw    alu      fl    push  e_ctl    flags    exec   skip
      // CMP then dependent EQ
      issue(1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 4'b1000, 4'b0100, 4'd1, 4'd0);
      issue(1'b1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1010, 4'b0100, 4'd2, 4'd0);
      // Partial flag writes
      issue(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b1000, 4'b1111, 4'd3, 4'd0);
      issue(1'b1, 4'hE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0011, 4'd4, 4'd0);
      issue(1'b1, 4'hE, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'd5, 4'd0);
      // Failed EQ must not write flags or memory
      issue(1'b1, 4'h0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'd5, 4'd1);
      // Flags N=1 Z=0 C=0 V=1, then a spread of conditions
      issue(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 4'b1000, 4'b1001, 4'd6, 4'd1);
      issue(1'b1, 4'hA, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1010, 4'b1001, 4'd7, 4'd1); // GE pass
      issue(1'b1, 4'h8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1001, 4'd7, 4'd2); // HI fail
      issue(1'b1, 4'hD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1001, 4'd7, 4'd3); // LE fail
      issue(1'b1, 4'h6, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1001, 4'b1001, 4'd8, 4'd3); // VS pass
      issue(1'b1, 4'h3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1100, 4'b1001, 4'd9, 4'd3); // CC pass
      issue(1'b1, 4'hB, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1001, 4'd9, 4'd4); // LT fail
      bubble();

      // Flag-setting AL held by a 3-edge stall; commits on release
      issue(1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 4'b1010, 4'b0110, 4'd10, 4'd4);
      stall(3, 4'b1001, 4'd9);
      // Released; this AL is later killed by flush+stall, so nothing queued
      issue(1'b1, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("fs_e_ctl", 32'({CondExE, PCSrcE, RegWriteE, MemWriteE}), 32'(pend_ctl));
      StallE    = 1'b1;
      FlushE    = 1'b1;
      ALUFlagsE = 4'hF;
      set_d(1'b1, 4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("fs_bubble", 32'({CondExE, PCSrcE, RegWriteE, MemWriteE}), 32'd0);
      chk("fs_validm", 32'(ValidM), 32'd0);
      chk("fs_flags", 32'(FlagsQ), 32'(4'b0110));
      chk("fs_exec", 32'(ExecCount), 32'd10);
      StallE    = 1'b0;
      FlushE    = 1'b0;
      ALUFlagsE = 4'h0;
      set_d(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      pend_ctl  = 4'b0000;
      pend_alu  = 4'b0000;

      // Flush without stall: E instr completes, incoming one is dropped
      issue(1'b1, 4'hE, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1011, 4'b0110, 4'd11, 4'd4);
      issue(1'b1, 4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0);
      issue(1'b1, 4'h1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0110, 4'd11, 4'd5); // NE fail
      bubble();

      // Mid-stream reset discards a flag-setting AL in E
      issue(1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1010, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("mr_e_ctl", 32'({CondExE, PCSrcE, RegWriteE, MemWriteE}), 32'(pend_ctl));
      reset     = 1'b1;
      ALUFlagsE = 4'hF;
      set_d(1'b1, 4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("mid_reset", all_outs(), 32'd0);
      reset     = 1'b0;
      ALUFlagsE = 4'h0;
      set_d(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      pend_ctl  = 4'b0000;
      pend_alu  = 4'b0000;

      // 16 executed instructions wrap the 4-bit counter back to 0
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1,
               4'b1010, 4'b0000, 4'(i + 1), 4'd0);
      end
      // Never-execute encoding
      issue(1'b1, 4'hF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'd0, 4'd1);
      bubble();
      bubble();

      t = 0;
      while (exp_q.size() != 0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
